// File: rtl/gemm_result_writer.sv
// GeMM result write-back: buffers result pulses in a small FIFO and
// streams them to output memory at consecutive addresses from a base.
module gemm_result_writer #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic                 result_valid_i,
  input  logic [DataWidth-1:0] result_data_i,
  output logic                 result_ready_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] M_count_o,
  output logic [AddrWidth-1:0] N_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = 2 * AddrWidth;

  localparam logic [AddrWidth-1:0] AOne = AddrWidth'(1);
  localparam logic [CntW-1:0]      COne = CntW'(1);
  localparam logic [PtrW-1:0]      POne = PtrW'(1);
  localparam logic [PtrW:0]        FOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]        Full = (PtrW + 1)'(FifoDepth);

  typedef enum logic [1:0] {
    Idle,
    Busy,
    Finish
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] m_q, n_q, base_q;
  logic [AddrWidth-1:0] widx_q, m_cnt_q, n_cnt_q;
  logic [CntW-1:0]      total_q, acc_q;
  logic [DataWidth-1:0] fifo_q [FifoDepth];
  logic [PtrW-1:0]      rptr_q, wptr_q;
  logic [PtrW:0]        cnt_q;
  logic                 ovf_q;

  logic full, empty, start_ok;
  logic push, pop, last;
  logic n_wrap;

  assign full     = (cnt_q == Full);
  assign empty    = (cnt_q == '0);
  assign start_ok = start_i && (state_q == Idle);

  assign result_ready_o = (state_q == Busy) && !full
                        && (acc_q < total_q);
  assign push = result_valid_i && result_ready_o;

  assign mem_req_o   = (state_q == Busy) && !empty;
  assign mem_addr_o  = base_q + widx_q;
  assign mem_wdata_o = mem_req_o ? fifo_q[rptr_q] : '0;
  assign pop         = mem_req_o && mem_gnt_i;

  assign n_wrap = (n_cnt_q == n_q - AOne);
  assign last   = n_wrap && (m_cnt_q == m_q - AOne);

  assign M_count_o  = m_cnt_q;
  assign N_count_o  = n_cnt_q;
  assign busy_o     = (state_q != Idle);
  assign overflow_o = ovf_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  // Next-state and completion pulse
  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    unique case (state_q)
      Idle: begin
        if (start_ok) begin
          if (M_size_i == '0 || N_size_i == '0)
            state_d = Finish;
          else
            state_d = Busy;
        end
      end
      Busy: begin
        if (pop && last) state_d = Finish;
      end
      Finish: begin
        done_o  = 1'b1;
        state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  // Sizes, counters, FIFO pointers and sticky overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      total_q <= '0;
      acc_q   <= '0;
      widx_q  <= '0;
      m_cnt_q <= '0;
      n_cnt_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (start_ok) begin
      m_q     <= M_size_i;
      n_q     <= N_size_i;
      base_q  <= base_addr_i;
      total_q <= CntW'(M_size_i) * CntW'(N_size_i);
      acc_q   <= '0;
      widx_q  <= '0;
      m_cnt_q <= '0;
      n_cnt_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (result_valid_i && !result_ready_o)
        ovf_q <= 1'b1;
      if (push) begin
        wptr_q <= wptr_q + POne;
        acc_q  <= acc_q + COne;
      end
      if (pop) begin
        rptr_q <= rptr_q + POne;
        widx_q <= widx_q + AOne;
        if (n_wrap) begin
          n_cnt_q <= '0;
          m_cnt_q <= m_cnt_q + AOne;
        end else begin
          n_cnt_q <= n_cnt_q + AOne;
        end
      end
      if (push && !pop)
        cnt_q <= cnt_q + FOne;
      else if (pop && !push)
        cnt_q <= cnt_q - FOne;
    end
  end

  // Result storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= result_data_i;
  end

endmodule

// File: doc/gemm_result_writer.md
# gemm_result_writer

Write-back end of the GeMM datapath. Consumes the one-cycle result pulses the GeMM controller emits per completed output element (row-major, N inner, M outer), buffers them in a small FIFO, and writes them to output memory through a req/gnt port at consecutive addresses from a base. Signals completion after all M×N results have been granted to memory.

## Interface
- AddrWidth, 16, width of sizes, counters and memory address
- DataWidth, 32, result/memory data width
- FifoDepth, 4, result buffer entries (power of two, ≥2)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; latches sizes/base, clears counters and overflow_o
- M_size_i  in  AddrWidth  output rows
- N_size_i  in  AddrWidth  output columns
- base_addr_i  in  AddrWidth  address of element (0,0)
- result_valid_i  in  1  result present (no backpressure upstream)
- result_data_i  in  DataWidth  result value
- result_ready_o  out  1  buffer can accept this cycle
- mem_req_o  out  1  write request
- mem_addr_o  out  AddrWidth  write address
- mem_wdata_o  out  DataWidth  write data
- mem_gnt_i  in  1  write accepted this cycle
- M_count_o  out  AddrWidth  row of element at FIFO head
- N_count_o  out  AddrWidth  column of element at FIFO head
- busy_o  out  1  state != Idle
- done_o  out  1  one-cycle completion pulse
- overflow_o  out  1  sticky: result dropped

## Operation
- States: Idle, Busy, Finish.
- Idle: result_ready_o=0, mem_req_o=0. start_i: latch M, N, base; clear write index, M/N counters, accept counter, FIFO, overflow_o. If M==0 or N==0 go Finish, else Busy.
- Busy: result_ready_o = !full && accepted < M·N (product computed at start, 2·AddrWidth bits). Push on result_valid_i && result_ready_o. mem_req_o = !empty; mem_wdata_o = FIFO head; mem_addr_o = base + write index (mod 2^AddrWidth).
- On mem_req_o && mem_gnt_i: pop, write index +1, N counter +1; N wraps at N_size−1 → 0 and M +1.
- Last grant (M_count_o==M−1, N_count_o==N−1) → Finish.
- Finish: done_o=1 for one cycle → Idle. Counters hold final values until next start.
- result_valid_i with result_ready_o=0 (any state, incl. FIFO full or surplus beyond M·N) sets overflow_o; data dropped. Cleared only by start_i or reset.
- No push when full, even if a pop occurs the same cycle. Push and pop in the same cycle when neither full nor empty: occupancy unchanged.
- start_i outside Idle ignored.

## Timing
- Reset values: state Idle, all outputs 0, FIFO empty, counters 0.
- Result accepted at edge t; mem_req_o high earliest in cycle t+1.
- With mem_gnt_i tied high, sustained throughput 1 write/cycle.
- While mem_req_o=1 and mem_gnt_i=0, mem_addr_o, mem_wdata_o, M/N_count_o hold stable.
- done_o asserted the cycle after the last grant; busy_o falls the cycle after done_o.
- Zero size: done_o in cycle after start_i, no mem_req_o.
- Reset mid-operation: immediate return to reset values; buffered data discarded.

## Test plan
- M=2,N=3, base=0x0100, six back-to-back results 1..6, gnt=1 → writes 0x0100..0x0105 with data 1..6 in order, done_o single pulse the cycle after 6th grant, overflow_o=0.
- FifoDepth=4, gnt=0 for 10 cycles, 6 results offered → 4 accepted, result_ready_o low from 5th, overflow_o=1; mem_addr_o stays base, then 4 writes after gnt released.
- M=1,N=2, three results → third dropped, overflow_o=1 sticky; next start_i clears it.
- M=0,N=5 start → done_o one cycle after start, mem_req_o never high.
- base=0xFFFE, M=1,N=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; M/N counts (0,0)..(0,3).
- Reset asserted after 3 of 6 writes → outputs 0 immediately; new start writes from base, count (0,0).
